// File: rtl/opb_reg_access_sequencer_pkg.sv
// Shared state/status types and OPB bus widths for the register-access sequencer.
package opb_seq_pkg;
  localparam int OPB_AWIDTH  = 32;
  localparam int OPB_DWIDTH  = 32;
  localparam int OPB_BEWIDTH = OPB_DWIDTH / 8;

  typedef enum logic [2:0] {IDLE, REQ, XFER, BACKOFF, RESP} seq_state_t;

  typedef enum logic [1:0] {
    RSP_OK        = 2'b00,
    RSP_ERRACK    = 2'b01,
    RSP_TIMEOUT   = 2'b10,
    RSP_RETRY_EXH = 2'b11
  } rsp_status_t;
endpackage

// File: rtl/opb_reg_access_sequencer_if.sv
// Command/response handshake plus OPB master-side bus signals; master = sequencer view.
interface opb_reg_access_sequencer_if;
  import opb_seq_pkg::*;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_rnw;
  logic [0:OPB_AWIDTH-1]  cmd_addr;
  logic [0:OPB_BEWIDTH-1] cmd_be;
  logic [0:OPB_DWIDTH-1]  cmd_wdata;

  logic                   rsp_valid;
  logic [0:OPB_DWIDTH-1]  rsp_rdata;
  logic [1:0]             rsp_status;

  logic                   M_request;
  logic                   OPB_MGrant;
  logic                   M_select;
  logic [0:OPB_AWIDTH-1]  M_ABus;
  logic [0:OPB_BEWIDTH-1] M_BE;
  logic [0:OPB_DWIDTH-1]  M_DBus;
  logic                   M_RNW;
  logic                   M_seqAddr;
  logic [0:OPB_DWIDTH-1]  OPB_DBus;
  logic                   OPB_xferAck;
  logic                   OPB_errAck;
  logic                   OPB_retry;
  logic                   OPB_toutSup;

  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
    output M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr
  );

  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
    input  M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr
  );
endinterface

// File: rtl/opb_reg_access_sequencer_cnt.sv
// Shared down-counter used for both the XFER timeout and the BACKOFF window.
module opb_seq_cnt #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/opb_reg_access_sequencer.sv
// OPB master issuing one single-beat read/write per accepted command, with bounded
// retry/backoff, errAck and local timeout handling, and exactly one response each.
module opb_reg_access_sequencer
  import opb_seq_pkg::*;
#(
  parameter int C_OPB_AWIDTH  = OPB_AWIDTH,
  parameter int C_OPB_DWIDTH  = OPB_DWIDTH,
  parameter int C_TOUT_CYCLES = 16,
  parameter int C_MAX_RETRY   = 7,
  parameter int C_BACKOFF     = 4
) (
  input logic                        OPB_Clk,
  input logic                        OPB_Rst_n,
  opb_reg_access_sequencer_if.master bus
);
  localparam int CNT_MAX = (C_TOUT_CYCLES > C_BACKOFF) ? C_TOUT_CYCLES : C_BACKOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(C_MAX_RETRY + 1);

  seq_state_t                state, state_nxt;
  logic                      rnw_q;
  logic [0:C_OPB_AWIDTH-1]   addr_q;
  logic [0:C_OPB_DWIDTH/8-1] be_q;
  logic [0:C_OPB_DWIDTH-1]   wdata_q;
  logic [RTY_W-1:0]          retry_cnt;
  logic [0:C_OPB_DWIDTH-1]   rdata_q, rdata_nxt;
  rsp_status_t               status_q, status_nxt;
  logic                      accept, retry_inc;
  logic                      cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]          cnt_load_val;

  opb_seq_cnt #(.WIDTH(CNT_W)) u_cnt (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt    = state;
    rdata_nxt    = rdata_q;
    status_nxt   = status_q;
    accept       = 1'b0;
    retry_inc    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.OPB_MGrant) begin
          state_nxt    = XFER;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(C_TOUT_CYCLES - 1);
        end
      end
      // Slave responses resolve as errAck > xferAck > retry > local timeout.
      XFER: begin
        cnt_dec = !bus.OPB_toutSup;
        if (bus.OPB_errAck) begin
          status_nxt = RSP_ERRACK;
          rdata_nxt  = '0;
          state_nxt  = RESP;
        end else if (bus.OPB_xferAck) begin
          status_nxt = RSP_OK;
          rdata_nxt  = rnw_q ? bus.OPB_DBus : '0;
          state_nxt  = RESP;
        end else if (bus.OPB_retry) begin
          if (retry_cnt == RTY_W'(C_MAX_RETRY)) begin
            status_nxt = RSP_RETRY_EXH;
            rdata_nxt  = '0;
            state_nxt  = RESP;
          end else begin
            retry_inc    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(C_BACKOFF - 1);
            state_nxt    = BACKOFF;
          end
        end else if (cnt_zero && !bus.OPB_toutSup) begin
          status_nxt = RSP_TIMEOUT;
          rdata_nxt  = '0;
          state_nxt  = RESP;
        end
      end
      BACKOFF: begin
        if (cnt_zero) state_nxt = REQ;
        else          cnt_dec   = 1'b1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state     <= IDLE;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      retry_cnt <= '0;
      rdata_q   <= '0;
      status_q  <= RSP_OK;
    end else begin
      state    <= state_nxt;
      rdata_q  <= rdata_nxt;
      status_q <= status_nxt;
      if (accept) begin
        rnw_q     <= bus.cmd_rnw;
        addr_q    <= bus.cmd_addr;
        be_q      <= bus.cmd_be;
        wdata_q   <= bus.cmd_wdata;
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + RTY_W'(1);
      end
    end
  end

  // All bus drivers are gated by M_select so idle cycles contribute zero to the OR-bus.
  assign bus.cmd_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_status = status_q;
  assign bus.M_request  = (state == REQ);
  assign bus.M_select   = (state == XFER);
  assign bus.M_ABus     = bus.M_select ? addr_q : '0;
  assign bus.M_BE       = bus.M_select ? be_q : '0;
  assign bus.M_DBus     = (bus.M_select && !rnw_q) ? wdata_q : '0;
  assign bus.M_RNW      = bus.M_select & rnw_q;
  assign bus.M_seqAddr  = 1'b0;
endmodule

// File: tb/tb_opb_reg_access_sequencer.sv
// Bench acting as arbiter + scripted slave per attempt; outcomes and cycle counts come
// from an attempt-level model of the retry/timeout/backoff rules.
module tb_opb_reg_access_sequencer;
  localparam int TOUT = 16, MAX_RETRY = 7, BACKOFF = 4, MAX_ATT = MAX_RETRY + 1;
  localparam int K_ACK = 0, K_ERR = 1, K_RETRY = 2, K_NONE = 3, K_BOTH = 4;

  logic OPB_Clk   = 1'b0;
  logic OPB_Rst_n = 1'b0;
  int   n_assert  = 0;
  int   n_fail    = 0;

  opb_reg_access_sequencer_if bus ();

  opb_reg_access_sequencer #(
    .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32), .C_TOUT_CYCLES(TOUT),
    .C_MAX_RETRY(MAX_RETRY), .C_BACKOFF(BACKOFF)
  ) dut (
    .OPB_Clk   (OPB_Clk),
    .OPB_Rst_n (OPB_Rst_n),
    .bus       (bus)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  int          att_kind [MAX_ATT];
  int          att_dly  [MAX_ATT];
  int          att_sup  [MAX_ATT];
  logic [0:31] slave_rdata;
  bit          hold_next;
  logic        nxt_rnw;
  logic [0:31] nxt_addr, nxt_wdata;
  logic [0:3]  nxt_be;

  logic [1:0]  obs_status, obs_after_status, exp_status;
  logic [0:31] obs_rdata, exp_rdata;
  logic        obs_after_valid, obs_after_ready;
  int          obs_att, obs_lat, obs_wait, obs_bus_err, obs_ready_err, obs_gap_err, obs_len_err;
  int          exp_att, exp_lat;
  int          exp_len [MAX_ATT];

  task automatic fill_script(input int kind, input int dly, input int sup);
    for (int a = 0; a < MAX_ATT; a++) begin
      att_kind[a] = kind;
      att_dly[a]  = dly;
      att_sup[a]  = sup;
    end
  endtask

  // Outcome per attempt: the response lands at its delay unless the (toutSup-stretched) timeout comes first.
  task automatic model_cmd(input logic rnw, input int gdly);
    int  tcyc;
    bit  done;
    done = 0; exp_att = 0; exp_lat = 1; exp_rdata = '0; exp_status = 2'b00;
    for (int a = 0; a < MAX_ATT && !done; a++) begin
      tcyc    = att_sup[a] + TOUT - 1;
      exp_att = a + 1;
      if (att_kind[a] == K_NONE || att_dly[a] > tcyc) begin
        exp_len[a] = tcyc + 1;
        exp_status = 2'b10;
        done       = 1;
      end else begin
        exp_len[a] = att_dly[a] + 1;
        case (att_kind[a])
          K_ACK:        begin exp_status = 2'b00; exp_rdata = rnw ? slave_rdata : 32'h0; done = 1; end
          K_ERR, K_BOTH: begin exp_status = 2'b01; done = 1; end
          default:      if (a == MAX_RETRY) begin exp_status = 2'b11; done = 1; end
        endcase
      end
      exp_lat += gdly + 1 + exp_len[a] + (done ? 0 : BACKOFF);
    end
  endtask

  task automatic clear_slave();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_errAck  = 1'b0;
    bus.OPB_retry   = 1'b0;
    bus.OPB_toutSup = 1'b0;
    bus.OPB_DBus    = $urandom;
  endtask

  // Issues one command and plays arbiter/slave each cycle, recording what the DUT did.
  task automatic applyStimulus(input logic rnw, input logic [0:31] addr, input logic [0:3] be,
                               input logic [0:31] wdata, input int gdly);
    int n, req_run, xcyc, gap, a;
    bit in_gap;
    model_cmd(rnw, gdly);
    obs_bus_err = 0; obs_ready_err = 0; obs_gap_err = 0; obs_len_err = 0;
    obs_att = 0; obs_lat = -1; obs_status = 2'bxx; obs_rdata = 'x;
    bus.cmd_valid = 1'b1; bus.cmd_rnw = rnw; bus.cmd_addr = addr; bus.cmd_be = be; bus.cmd_wdata = wdata;
    obs_wait = 0;
    while (bus.cmd_ready !== 1'b1 && obs_wait < 50) begin
      @(posedge OPB_Clk); #1; obs_wait++;
    end
    @(posedge OPB_Clk); #1;
    n = 1; req_run = 0; xcyc = 0; gap = 0; in_gap = 0;
    if (hold_next) begin
      bus.cmd_rnw = nxt_rnw; bus.cmd_addr = nxt_addr; bus.cmd_be = nxt_be; bus.cmd_wdata = nxt_wdata;
    end else begin
      bus.cmd_valid = 1'b0; bus.cmd_rnw = ~rnw; bus.cmd_addr = $urandom; bus.cmd_be = ~be; bus.cmd_wdata = $urandom;
    end
    while (n < 2000) begin
      clear_slave();
      if (bus.cmd_ready !== 1'b0) obs_ready_err++;
      if (bus.M_select !== 1'b1 && xcyc > 0) begin
        if (obs_att >= 1 && obs_att <= MAX_ATT && xcyc != exp_len[obs_att-1]) obs_len_err++;
        xcyc = 0; in_gap = 1; gap = 0;
      end
      if (bus.rsp_valid === 1'b1) begin
        obs_lat = n; obs_status = bus.rsp_status; obs_rdata = bus.rsp_rdata;
        break;
      end
      if (bus.M_request === 1'b1) begin
        if (in_gap && gap != BACKOFF) obs_gap_err++;
        in_gap = 0;
        bus.OPB_MGrant = (req_run >= gdly);
        req_run++;
      end else begin
        req_run = 0;
      end
      if (bus.M_select === 1'b1) begin
        if (xcyc == 0) obs_att++;
        if (bus.M_request !== 1'b0 || bus.M_ABus !== addr || bus.M_BE !== be || bus.M_RNW !== rnw ||
            (!rnw && bus.M_DBus !== wdata)) obs_bus_err++;
        if (obs_att <= MAX_ATT) begin
          a = obs_att - 1;
          bus.OPB_toutSup = (xcyc < att_sup[a]);
          if (xcyc == att_dly[a]) begin
            case (att_kind[a])
              K_ACK:   begin bus.OPB_xferAck = 1'b1; bus.OPB_DBus = slave_rdata; end
              K_ERR:   bus.OPB_errAck = 1'b1;
              K_RETRY: bus.OPB_retry = 1'b1;
              K_BOTH:  begin bus.OPB_errAck = 1'b1; bus.OPB_xferAck = 1'b1; bus.OPB_DBus = slave_rdata; end
              default: ;
            endcase
          end
        end
        xcyc++;
      end else begin
        if ({bus.M_ABus, bus.M_BE, bus.M_DBus, bus.M_RNW} !== '0) obs_bus_err++;
        if (in_gap && bus.M_request !== 1'b1) gap++;
      end
      if (bus.M_seqAddr !== 1'b0) obs_bus_err++;
      @(posedge OPB_Clk); #1; n++;
    end
    clear_slave();
    @(posedge OPB_Clk); #1;
    obs_after_valid = bus.rsp_valid; obs_after_ready = bus.cmd_ready; obs_after_status = bus.rsp_status;
  endtask

  task automatic test_reset();
    OPB_Rst_n = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    n_assert++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.cmd_ready); end
    n_assert++; if ({bus.M_request, bus.M_select, bus.M_ABus, bus.M_BE, bus.M_DBus, bus.M_RNW, bus.M_seqAddr, bus.rsp_valid, bus.rsp_rdata, bus.rsp_status} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %h expected 0", {bus.M_request, bus.M_select, bus.M_ABus, bus.M_BE, bus.M_DBus, bus.M_RNW, bus.M_seqAddr, bus.rsp_valid, bus.rsp_rdata, bus.rsp_status}); end
    #2 OPB_Rst_n = 1'b1;
    @(posedge OPB_Clk); #1;
    n_assert++; if (bus.cmd_ready !== 1'b1 || bus.M_request !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: got ready=%b req=%b expected 1/0", bus.cmd_ready, bus.M_request); end
  endtask

  task automatic test_write_basic();
    fill_script(K_ACK, 0, 0);
    applyStimulus(1'b0, 32'h010B0004, 4'hF, 32'hDEADBEEF, 1);
    n_assert++; if (obs_status !== 2'b00) begin n_fail++; $display("[TB] FAIL write_status: got %b expected 00", obs_status); end
    n_assert++; if (obs_bus_err !== 0) begin n_fail++; $display("[TB] FAIL write_bus: got %0d bad bus cycles expected 0", obs_bus_err); end
    n_assert++; if (obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL write_latency: got %0d expected %0d", obs_lat, exp_lat); end
    n_assert++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL write_rsp_pulse: got valid=%b ready=%b expected 0/1", obs_after_valid, obs_after_ready); end
  endtask

  task automatic test_latency_min();
    fill_script(K_ACK, 0, 0);
    slave_rdata = 32'hA5A5_0F0F;
    applyStimulus(1'b1, 32'h010B0008, 4'hF, 32'h0, 0);
    n_assert++; if (obs_lat !== 3) begin n_fail++; $display("[TB] FAIL min_latency: got %0d expected 3", obs_lat); end
    n_assert++; if (obs_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("[TB] FAIL min_rdata: got %h expected a5a50f0f", obs_rdata); end
  endtask

  task automatic test_read_wait();
    fill_script(K_ACK, 2, 0);
    slave_rdata = 32'h12345678;
    applyStimulus(1'b1, 32'h010B0000, 4'hF, $urandom, 0);
    n_assert++; if (obs_rdata !== 32'h12345678 || obs_status !== 2'b00) begin n_fail++; $display("[TB] FAIL read_data: got %h/%b expected 12345678/00", obs_rdata, obs_status); end
    n_assert++; if (obs_len_err !== 0 || obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL read_timing: got lenerr=%0d lat=%0d expected 0/%0d", obs_len_err, obs_lat, exp_lat); end
    n_assert++; if (obs_after_status !== 2'b00) begin n_fail++; $display("[TB] FAIL read_status_hold: got %b expected 00", obs_after_status); end
  endtask

  task automatic test_retry_twice();
    fill_script(K_ACK, 0, 0);
    att_kind[0] = K_RETRY; att_kind[1] = K_RETRY;
    applyStimulus(1'b0, 32'h010B000C, 4'h3, 32'hCAFE_0001, 0);
    n_assert++; if (obs_att !== 3) begin n_fail++; $display("[TB] FAIL retry2_attempts: got %0d expected 3", obs_att); end
    n_assert++; if (obs_gap_err !== 0) begin n_fail++; $display("[TB] FAIL retry2_backoff: got %0d bad windows expected 0", obs_gap_err); end
    n_assert++; if (obs_status !== 2'b00 || obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL retry2_result: got %b lat %0d expected 00 lat %0d", obs_status, obs_lat, exp_lat); end
  endtask

  task automatic test_retry_exhaust();
    fill_script(K_RETRY, 1, 0);
    slave_rdata = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 32'h010B0010, 4'hF, 32'h0, 1);
    n_assert++; if (obs_att !== 8) begin n_fail++; $display("[TB] FAIL exhaust_attempts: got %0d expected 8", obs_att); end
    n_assert++; if (obs_status !== 2'b11 || obs_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL exhaust_result: got %b/%h expected 11/0", obs_status, obs_rdata); end
    n_assert++; if (obs_gap_err !== 0 || obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL exhaust_timing: got gaperr=%0d lat=%0d expected 0/%0d", obs_gap_err, obs_lat, exp_lat); end
  endtask

  task automatic test_timeout();
    fill_script(K_NONE, 0, 0);
    applyStimulus(1'b1, 32'h010B0014, 4'hF, 32'h0, 0);
    n_assert++; if (obs_status !== 2'b10 || obs_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL timeout_result: got %b/%h expected 10/0", obs_status, obs_rdata); end
    n_assert++; if (obs_len_err !== 0 || obs_lat !== 2 + TOUT) begin n_fail++; $display("[TB] FAIL timeout_cycles: got lenerr=%0d lat=%0d expected 0/%0d", obs_len_err, obs_lat, 2 + TOUT); end
  endtask

  task automatic test_tout_sup();
    fill_script(K_ACK, 40, 40);
    slave_rdata = 32'h0BAD_F00D;
    applyStimulus(1'b1, 32'h010B0018, 4'hF, 32'h0, 0);
    n_assert++; if (obs_status !== 2'b00 || obs_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("[TB] FAIL toutsup_result: got %b/%h expected 00/0badf00d", obs_status, obs_rdata); end
    n_assert++; if (obs_len_err !== 0 || obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL toutsup_cycles: got lenerr=%0d lat=%0d expected 0/%0d", obs_len_err, obs_lat, exp_lat); end
  endtask

  task automatic test_err_and_ack();
    fill_script(K_BOTH, 1, 0);
    slave_rdata = 32'h7777_7777;
    applyStimulus(1'b1, 32'h010B001C, 4'hF, 32'h0, 2);
    n_assert++; if (obs_status !== 2'b01 || obs_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL erracK_priority: got %b/%h expected 01/0", obs_status, obs_rdata); end
  endtask

  task automatic test_back_to_back();
    fill_script(K_ACK, 0, 0);
    hold_next = 1; nxt_rnw = 1'b0; nxt_addr = 32'h010B0020; nxt_be = 4'h5; nxt_wdata = 32'h1357_9BDF;
    applyStimulus(1'b0, 32'h010B0024, 4'hA, 32'h2468_ACE0, 0);
    hold_next = 0;
    n_assert++; if (obs_ready_err !== 0) begin n_fail++; $display("[TB] FAIL b2b_ready_busy: got %0d ready cycles expected 0", obs_ready_err); end
    n_assert++; if (obs_after_ready !== 1'b1 || obs_status !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_first: got ready=%b status=%b expected 1/00", obs_after_ready, obs_status); end
    applyStimulus(nxt_rnw, nxt_addr, nxt_be, nxt_wdata, 0);
    n_assert++; if (obs_wait !== 0 || obs_bus_err !== 0 || obs_status !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_second: got wait=%0d buserr=%0d status=%b expected 0/0/00", obs_wait, obs_bus_err, obs_status); end
  endtask

  task automatic test_random();
    int r, gdly;
    logic rnw;
    for (int i = 0; i < 25; i++) begin
      for (int a = 0; a < MAX_ATT; a++) begin
        r = $urandom_range(0, 9);
        att_kind[a] = (r < 5) ? K_ACK : (r == 5) ? K_ERR : (r == 6) ? K_BOTH : (r < 9) ? K_RETRY : K_NONE;
        att_dly[a]  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 22) : $urandom_range(0, 4);
        att_sup[a]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      end
      slave_rdata = $urandom;
      rnw  = 1'($urandom_range(0, 1));
      gdly = $urandom_range(0, 3);
      applyStimulus(rnw, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)), $urandom, gdly);
      n_assert++; if (obs_status !== exp_status || obs_rdata !== exp_rdata) begin n_fail++; $display("[TB] FAIL rand%0d_rsp: got %b/%h expected %b/%h", i, obs_status, obs_rdata, exp_status, exp_rdata); end
      n_assert++; if (obs_att !== exp_att || obs_lat !== exp_lat) begin n_fail++; $display("[TB] FAIL rand%0d_timing: got att=%0d lat=%0d expected %0d/%0d", i, obs_att, obs_lat, exp_att, exp_lat); end
      n_assert++; if (obs_bus_err + obs_gap_err + obs_len_err + obs_ready_err !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_protocol: got bus=%0d gap=%0d len=%0d rdy=%0d expected all 0", i, obs_bus_err, obs_gap_err, obs_len_err, obs_ready_err); end
      n_assert++; if (obs_after_valid !== 1'b0 || obs_after_status !== exp_status) begin n_fail++; $display("[TB] FAIL rand%0d_hold: got valid=%b status=%b expected 0/%b", i, obs_after_valid, obs_after_status, exp_status); end
    end
  endtask

  // Reset lands mid-cycle while a transfer is on the bus; outputs must clear without waiting for an edge.
  task automatic test_reset_mid_xfer();
    bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b0; bus.cmd_addr = 32'h010B0030; bus.cmd_be = 4'hF; bus.cmd_wdata = 32'h5555_AAAA;
    @(posedge OPB_Clk); #1;
    bus.cmd_valid = 1'b0; bus.OPB_MGrant = 1'b1;
    @(posedge OPB_Clk); #1;
    bus.OPB_MGrant = 1'b0;
    n_assert++; if (bus.M_select !== 1'b1 || bus.M_ABus !== 32'h010B0030) begin n_fail++; $display("[TB] FAIL rstx_in_xfer: got sel=%b addr=%h expected 1/010b0030", bus.M_select, bus.M_ABus); end
    #2 OPB_Rst_n = 1'b0;
    #1;
    n_assert++; if ({bus.M_request, bus.M_select, bus.M_ABus, bus.M_BE, bus.M_DBus, bus.M_RNW, bus.rsp_valid, bus.rsp_rdata, bus.rsp_status} !== '0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rstx_async_clear: got sel=%b abus=%h dbus=%h ready=%b expected 0/0/0/1", bus.M_select, bus.M_ABus, bus.M_DBus, bus.cmd_ready); end
    @(posedge OPB_Clk); #3 OPB_Rst_n = 1'b1;
    @(posedge OPB_Clk); #1;
    n_assert++; if (bus.cmd_ready !== 1'b1 || bus.M_request !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstx_idle_after: got ready=%b req=%b rsp=%b expected 1/0/0", bus.cmd_ready, bus.M_request, bus.rsp_valid); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0; bus.cmd_be = '0; bus.cmd_wdata = '0;
    bus.OPB_MGrant = 1'b0; bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0; bus.OPB_retry = 1'b0;
    bus.OPB_toutSup = 1'b0; bus.OPB_DBus = '0;
    hold_next = 0; slave_rdata = '0;
    test_reset();
    test_write_basic();
    test_latency_min();
    test_read_wait();
    test_retry_twice();
    test_retry_exhaust();
    test_timeout();
    test_tout_sup();
    test_err_and_ack();
    test_back_to_back();
    test_random();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
